// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the serial-in / parallel-out deserializer.
// The master drives the serial side and the consumer ready. The slave is the deserializer itself.
interface sipo_deserializer_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic             shift;
   logic             sin;
   logic             sync;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic             out_valid;
   logic [CW-1:0]    bit_cnt;
   logic             overrun;

   modport master (
      output shift, sin, sync, out_ready,
      input  out_word, out_valid, bit_cnt, overrun
   );

   modport slave (
      input  shift, sin, sync, out_ready,
      output out_word, out_valid, bit_cnt, overrun
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a one-word output slot.
// Serial bits are collected into shreg. A completed word moves straight into out_word when the
// slot is free. Otherwise the word waits in shreg (STALL) until the consumer takes the
// previous word. Bits that arrive while stalled are dropped and flagged as overrun.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk_i,
   input logic                rst_i,
   sipo_deserializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_STALL   = 2'd2;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             slot_free_s;
   logic [WIDTH-1:0] shifted_s;

   // Insert one serial bit into the partial word according to the bit order
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      logic [WIDTH-1:0] res;
      if (MSB_FIRST) begin
         res = {cur[WIDTH-2:0], b};
      end else begin
         res = {b, cur[WIDTH-1:1]};
      end
      return res;
   endfunction

   assign slot_free_s = !valid_q || bus.out_ready;
   assign shifted_s   = shift_in(shreg_q, bus.sin);

   // Next-state logic: sync restart, serial collection, stall handling and output handshake
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      // Handshake. A word loaded later in this block overrides the clear.
      if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (bus.sync) begin
         state_d = ST_IDLE;
         shreg_d = {WIDTH{1'b0}};
         cnt_d   = CNT_ZERO;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_COLLECT: begin
               if (bus.shift) begin
                  if (cnt_q == CNT_LAST) begin
                     if (slot_free_s) begin
                        word_d  = shifted_s;
                        valid_d = 1'b1;
                        shreg_d = {WIDTH{1'b0}};
                        cnt_d   = CNT_ZERO;
                        state_d = ST_IDLE;
                     end else begin
                        shreg_d = shifted_s;
                        cnt_d   = CNT_FULL;
                        state_d = ST_STALL;
                     end
                  end else begin
                     shreg_d = shifted_s;
                     cnt_d   = cnt_q + CW'(1);
                     state_d = ST_COLLECT;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_STALL: begin
               if (bus.shift) begin
                  ovr_d = 1'b1;
               end else begin
                  ovr_d = ovr_q;
               end
               if (bus.out_ready) begin
                  word_d  = shreg_q;
                  valid_d = 1'b1;
                  shreg_d = {WIDTH{1'b0}};
                  cnt_d   = CNT_ZERO;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_STALL;
               end
            end
            default: begin
               state_d = ST_IDLE;
               shreg_d = {WIDTH{1'b0}};
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         shreg_q <= {WIDTH{1'b0}};
         cnt_q   <= CNT_ZERO;
         word_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.out_word  = word_q;
   assign bus.out_valid = valid_q;
   assign bus.bit_cnt   = cnt_q;
   assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. It uses an MSB-first instance and an LSB-first instance
// that receive the same stimulus.
module tb_sipo_deserializer;
   logic clk;
   logic rst;
   logic shift_r, sin_r, sync_r, ready_r;

   sipo_deserializer_if #(.WIDTH(4)) if_m ();
   sipo_deserializer_if #(.WIDTH(4)) if_l ();

   assign if_m.shift = shift_r;  assign if_m.sin = sin_r;
   assign if_m.sync  = sync_r;   assign if_m.out_ready = ready_r;
   assign if_l.shift = shift_r;  assign if_l.sin = sin_r;
   assign if_l.sync  = sync_r;   assign if_l.out_ready = ready_r;

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk_i(clk), .rst_i(rst), .bus(if_m.slave));
   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk_i(clk), .rst_i(rst), .bus(if_l.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       shift, sin, sync, rdy;
      logic [3:0] word;
      logic       valid;
      logic [2:0] cnt;
      logic       ovr;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic sh, input logic s, input logic sy, input logic r,
                      input logic [3:0] w, input logic v, input logic [2:0] c, input logic o);
      vec_t e;
      e.shift = sh; e.sin = s; e.sync = sy; e.rdy = r;
      e.word = w; e.valid = v; e.cnt = c; e.ovr = o;
      tbl.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_m(input string tag, input logic [3:0] w, input logic v,
                          input logic [2:0] c, input logic o);
      check({tag, ".word"},  32'(if_m.out_word),  32'(w));
      check({tag, ".valid"}, 32'(if_m.out_valid), 32'(v));
      check({tag, ".cnt"},   32'(if_m.bit_cnt),   32'(c));
      check({tag, ".ovr"},   32'(if_m.overrun),   32'(o));
   endtask

   // Shift a 4-bit pattern, oldest bit first from pat[3], one bit per edge
   task automatic send4(input logic [3:0] pat);
      for (int i = 0; i < 4; i++) begin
         shift_r = 1'b1; sin_r = pat[3-i];
         step();
      end
      shift_r = 1'b0; sin_r = 1'b0;
   endtask

   initial begin
      logic [3:0] pat;
      shift_r = 1'b0; sin_r = 1'b0; sync_r = 1'b0; ready_r = 1'b0;
      rst = 1'b1;
      #1;
      check_m("reset", 4'h0, 1'b0, 3'd0, 1'b0);
      #11 rst = 1'b0;

      //     sh    sin   sync  rdy   word     valid cnt   ovr
      // Word 1011, consumer ready: valid is high for exactly one cycle
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd2, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd3, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 3'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 3'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 3'd0, 1'b0);
      // Consumer stalled: 1011 is delivered, then 0110 stalls in the shift register
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b0, 3'd1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b0, 3'd2, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b0, 3'd3, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 3'd1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd2, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd3, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 3'd4, 1'b0);
      // Shift while stalled sets overrun; sync clears it and discards the stalled word
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd4, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b1, 3'd0, 1'b0);
      // Stall 0110 again, then release it with a shift on the release edge
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 3'd1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd2, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd3, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 3'd4, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'h6, 1'b1, 3'd0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 1'b1, 3'd0, 1'b1);
      // Sync combined with a handshake: the word transfers and overrun clears
      add(1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 3'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 3'd0, 1'b0);
      // A new word loads on the same edge as the handshake, so valid stays high
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 3'd1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 3'd2, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 3'd3, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 3'd0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 3'd1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 3'd2, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 3'd3, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 3'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);

      foreach (tbl[i]) begin
         shift_r = tbl[i].shift; sin_r = tbl[i].sin;
         sync_r  = tbl[i].sync;  ready_r = tbl[i].rdy;
         step();
         check_m($sformatf("row%0d", i), tbl[i].word, tbl[i].valid, tbl[i].cnt, tbl[i].ovr);
      end
      shift_r = 1'b0; sin_r = 1'b0; sync_r = 1'b0; ready_r = 1'b1;

      // Gaps of 1..3 idle cycles between bits; bit_cnt holds across each gap
      pat = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         shift_r = 1'b1; sin_r = pat[3-i];
         step();
         shift_r = 1'b0;
         if (i < 3) begin
            for (int g = 0; g <= i; g++) begin
               check($sformatf("gap%0d_%0d.cnt", i, g), 32'(if_m.bit_cnt), 32'(i + 1));
               step();
            end
            check($sformatf("gap%0d.valid", i), 32'(if_m.out_valid), 32'(0));
         end else begin
            check("gap.word", 32'(if_m.out_word), 32'(4'hB));
            check("gap.valid", 32'(if_m.out_valid), 32'(1));
            check("gap.cnt", 32'(if_m.bit_cnt), 32'(0));
         end
      end

      // Sync mid-word discards two bits; the sin of the sync cycle is ignored
      shift_r = 1'b1; sin_r = 1'b1; step();
      shift_r = 1'b1; sin_r = 1'b0; step();
      check("pre_sync.cnt", 32'(if_m.bit_cnt), 32'(2));
      sync_r = 1'b1; shift_r = 1'b1; sin_r = 1'b1; step();
      sync_r = 1'b0;
      check("sync.cnt", 32'(if_m.bit_cnt), 32'(0));
      send4(4'b1100);
      check("sync_word", 32'(if_m.out_word), 32'(4'hC));
      check("sync_valid", 32'(if_m.out_valid), 32'(1));

      // Asynchronous reset between edges, in the middle of a word
      shift_r = 1'b1; sin_r = 1'b1; step();
      shift_r = 1'b1; sin_r = 1'b1; step();
      shift_r = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_m("async_rst", 4'h0, 1'b0, 3'd0, 1'b0);
      check("async_rst.lsb_word", 32'(if_l.out_word), 32'(0));
      #1 rst = 1'b0;

      // The first shift after reset is bit 1 of a fresh word
      send4(4'b1011);
      check("post_rst.word", 32'(if_m.out_word), 32'(4'hB));
      check("post_rst.valid", 32'(if_m.out_valid), 32'(1));

      // LSB-first ordering: bits 1,1,0,1 give 1011 there and 1101 on the MSB-first instance
      send4(4'b1101);
      check("lsb_first.word", 32'(if_l.out_word), 32'(4'hB));
      check("lsb_first.valid", 32'(if_l.out_valid), 32'(1));
      check("msb_first.word", 32'(if_m.out_word), 32'(4'hD));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits, minimum 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in word MSB (matches a left-shifting PISO); 0 = first bit lands in LSB.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 shift  input  1  serial-bit strobe; sin is sampled only on edges where shift=1.
REQ-006 sin  input  1  serial data bit.
REQ-007 sync  input  1  synchronous frame restart; discards the partial word.
REQ-008 out_word  output  WIDTH  assembled parallel word.
REQ-009 out_valid  output  1  out_word holds an undelivered word.
REQ-010 out_ready  input  1  consumer accepts out_word on this edge.
REQ-011 bit_cnt  output  clog2(WIDTH)+1  bits currently held in the shift register.
REQ-012 overrun  output  1  sticky flag: a serial bit was dropped.

Function
REQ-013 FSM states: IDLE (bit_cnt=0), COLLECT (0<bit_cnt<WIDTH), STALL (complete word held, output slot busy).
REQ-014 In IDLE/COLLECT, shift=1 shifts sin into the shift register and increments bit_cnt; shift=0 holds all state.
REQ-015 MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}; MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
REQ-016 Output slot free on an edge when out_valid=0 or out_ready=1.
REQ-017 On the edge sampling the WIDTH-th bit with slot free: out_word <= completed word, out_valid <= 1, bit_cnt <= 0, state -> IDLE.
REQ-018 The same event with slot busy: completed word retained in shreg, bit_cnt = WIDTH, state -> STALL.
REQ-019 Latency: out_valid is high in the cycle immediately after the edge sampling the last bit; no extra pipeline stage.
REQ-020 Handshake: transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid then clears unless a new word loads on the same edge.
REQ-021 out_word is stable while out_valid=1 and out_ready=0.
REQ-022 In STALL, an out_ready=1 edge moves shreg to out_word, keeps out_valid=1, sets bit_cnt <= 0, and returns to IDLE.
REQ-023 In STALL, shift=1 drops the bit and sets overrun=1, including on the release edge of REQ-022.
REQ-024 overrun clears only on reset or sync.
REQ-025 sync=1 has priority over shift: shreg <= 0, bit_cnt <= 0, overrun <= 0, state -> IDLE; a stalled word is discarded and the sin of that cycle is ignored.
REQ-026 sync leaves out_word/out_valid untouched; the handshake of REQ-020 still applies on that edge.
REQ-027 out_ready while out_valid=0 has no effect.

Reset
REQ-028 reset=1 immediately, without a clock edge, forces out_word=0, out_valid=0, bit_cnt=0, overrun=0, shreg=0, state IDLE.
REQ-029 After reset deasserts, the first shift edge is bit 1 of a new word; any partial word from before reset is lost.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-030 Reset, out_ready=1, shift on 4 consecutive edges with sin=1,0,1,1 -> out_word=4'b1011, out_valid high for exactly one cycle, bit_cnt returns to 0.
REQ-031 Same bits with shift=0 gaps of 1-3 cycles between bits -> out_word=4'b1011; bit_cnt holds 1, 2, 3 across the gaps.
REQ-032 out_ready=0, send 1011 then 0110 -> out_word=1011, bit_cnt=4 (STALL); raise out_ready one cycle -> out_word=0110, out_valid stays 1; the next out_ready edge clears out_valid.
REQ-033 In STALL, pulse shift with sin=1 -> overrun=1, out_word and stalled word unchanged; then sync -> overrun=0, stalled word discarded, out_word=1011 still valid.
REQ-034 Shift 2 bits, assert sync, then shift 1,1,0,0 -> out_word=4'b1100; assert reset mid-word between edges -> all outputs 0 before the next clock edge.
REQ-035 MSB_FIRST=0, shift sin=1,1,0,1 -> out_word=4'b1011.
